// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution / 2x2 max-pool engine with two line buffers
// and a fixed three-stage pipeline behind a registered output stage.
module conv3x3_stream_engine #(
    parameter int DATA_W    = 8,
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 8,
    parameter int MAX_WIDTH = 128,
    parameter int DIM_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  relu_en,
    input  logic [4:0]            shift,
    input  logic [DIM_W-1:0]      width,
    input  logic [DIM_W-1:0]      height,
    input  logic [9*WEIGHT_W-1:0] weights,
    input  logic [ACC_W-1:0]      bias,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     pixel_in,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      pixel_out,
    output logic                  busy,
    output logic                  done
);
    localparam int PW     = DATA_W + WEIGHT_W;
    localparam int LB_AW  = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int STAGES = 3;
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (OUT_W-1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                   state_q;
    logic                     busy_q, done_q;
    logic [DIM_W-1:0]         col_q, row_q;
    logic                     mode_q, relu_en_q;
    logic [4:0]               shift_q;
    logic [DIM_W-1:0]         width_q, height_q;
    logic [9*WEIGHT_W-1:0]    weights_q;
    logic signed [ACC_W-1:0]  bias_q;

    logic signed [DATA_W-1:0] lb0_mem [MAX_WIDTH];
    logic signed [DATA_W-1:0] lb1_mem [MAX_WIDTH];
    logic signed [DATA_W-1:0] win_q [3][3];
    logic signed [DATA_W-1:0] win_d [3][3];
    logic signed [PW-1:0]     prod_q [9];
    logic signed [PW-1:0]     prod_d [9];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [STAGES:0]          vld_pipe_q, vld_pipe_d;
    logic [OUT_W-1:0]         pixel_out_q, pixel_out_d;

    logic                     accept, complete, last_pix;
    logic [LB_AW-1:0]         lb_idx;
    logic signed [DATA_W-1:0] lb_top, lb_mid;

    assign accept   = (state_q == S_RUN) && in_valid;
    assign complete = mode_q ? (row_q[0] & col_q[0])
                             : ((row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2)));
    assign last_pix = (row_q == height_q - DIM_W'(1)) && (col_q == width_q - DIM_W'(1));
    assign lb_idx   = col_q[LB_AW-1:0];
    assign lb_top   = lb1_mem[lb_idx];
    assign lb_mid   = lb0_mem[lb_idx];

    assign out_valid = vld_pipe_q[STAGES];
    assign pixel_out = pixel_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
        else                  sat = v[OUT_W-1:0];
    endfunction

    // Frame control; start in the done cycle is deliberately dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= 1'b0;
            relu_en_q <= 1'b0;
            shift_q   <= '0;
            width_q   <= '0;
            height_q  <= '0;
            weights_q <= '0;
            bias_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !done_q) begin
                        mode_q    <= mode;
                        relu_en_q <= relu_en;
                        shift_q   <= shift;
                        width_q   <= width;
                        height_q  <= height;
                        weights_q <= weights;
                        bias_q    <= $signed(bias);
                        col_q     <= '0;
                        row_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        if (last_pix) state_q <= S_DRAIN;
                        if (col_q == width_q - DIM_W'(1)) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (vld_pipe_q[STAGES-1:0] == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // lb0 holds the previous row, lb1 the row before that.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[lb_idx] <= lb0_mem[lb_idx];
            lb0_mem[lb_idx] <= pixel_in;
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_top;
            win_d[1][2] = lb_mid;
            win_d[2][2] = pixel_in;
        end
        vld_pipe_d = {vld_pipe_q[STAGES-1:0], accept && complete};
    end

    always_comb begin
        logic signed [WEIGHT_W-1:0] wk;
        logic signed [DATA_W-1:0]   m_a, m_b;
        wk  = '0;
        m_a = (win_q[1][1] > win_q[1][2]) ? win_q[1][1] : win_q[1][2];
        m_b = (win_q[2][1] > win_q[2][2]) ? win_q[2][1] : win_q[2][2];
        for (int k = 0; k < 9; k++) begin
            wk = weights_q[k*WEIGHT_W +: WEIGHT_W];
            prod_d[k] = PW'(win_q[k/3][k%3]) * PW'(wk);
        end
        if (mode_q) begin
            for (int k = 0; k < 9; k++) prod_d[k] = '0;
            prod_d[0] = PW'(m_a);
            prod_d[1] = PW'(m_b);
        end
    end

    always_comb begin
        acc_d = bias_q;
        for (int k = 0; k < 9; k++) acc_d = acc_d + ACC_W'(prod_q[k]);
        if (mode_q) acc_d = ACC_W'((prod_q[0] > prod_q[1]) ? prod_q[0] : prod_q[1]);
    end

    // Requantise with round-half-up, optional ReLU, then saturate.
    always_comb begin
        logic signed [ACC_W-1:0] rnd, res;
        rnd = (shift_q == 5'd0) ? '0 : (ACC_W'(1) << (shift_q - 5'd1));
        res = (acc_q + rnd) >>> shift_q;
        if (relu_en_q && res[ACC_W-1]) res = '0;
        if (mode_q) res = acc_q;
        pixel_out_d = vld_pipe_q[STAGES-1] ? sat(res) : pixel_out_q;
    end

    always_ff @(posedge clk) begin
        win_q  <= win_d;
        prod_q <= prod_d;
        acc_q  <= acc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            pixel_out_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            pixel_out_q <= pixel_out_d;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed bench for conv3x3_stream_engine: conv, rounding, ReLU, saturation,
// max-pool, stalls and mid-frame reset, with per-output latency checks.
module tb_conv3x3_stream_engine;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, relu_en = 1'b0;
    logic [4:0]  shift = '0;
    logic [7:0]  width = '0, height = '0;
    logic [71:0] weights = '0;
    logic [31:0] bias = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  pixel_in = '0;
    logic        out_valid, busy, done;
    logic [7:0]  pixel_out;

    conv3x3_stream_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .relu_en(relu_en),
        .shift(shift), .width(width), .height(height), .weights(weights), .bias(bias),
        .in_valid(in_valid), .pixel_in(pixel_in), .out_valid(out_valid),
        .pixel_out(pixel_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int outq[$], outc[$], compc[$];
    int done_cnt = 0, done_cyc = 0;
    logic busy_at_done = 1'b1;

    always @(negedge clk) begin
        if (out_valid) begin
            outq.push_back($signed(pixel_out));
            outc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input bit m, input bit r, input logic [4:0] sh, input logic [71:0] w,
                             input logic [31:0] b, input int wd, input int ht,
                             input int pat, input int cval, input int gapmax);
        outq.delete(); outc.delete(); compc.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        mode = m; relu_en = r; shift = sh; weights = w; bias = b;
        width = 8'(wd); height = 8'(ht); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
        for (int rr = 0; rr < ht; rr++) begin
            for (int cc = 0; cc < wd; cc++) begin
                if (gapmax > 0) begin
                    repeat ($urandom_range(gapmax, 0)) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b1;
                pixel_in = (pat != 0) ? 8'(rr*wd + cc) : 8'(cval);
                @(posedge clk); #1;
                if (m ? ((rr % 2 == 1) && (cc % 2 == 1)) : (rr >= 2 && cc >= 2))
                    compc.push_back(cyc);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int n, input int e0, input int e1,
                               input int e2, input int e3);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        chk({tag, "_count"}, outq.size(), n);
        for (int i = 0; i < n && i < outq.size(); i++) begin
            chk($sformatf("%s_val%0d", tag, i), outq[i], ev[i]);
            if (i < compc.size())
                chk($sformatf("%s_lat%0d", tag, i), outc[i] - compc[i], 3);
        end
        chk({tag, "_done_once"}, done_cnt, 1);
        if (outc.size() > 0) chk({tag, "_done_timing"}, done_cyc - outc[outc.size()-1], 1);
        chk({tag, "_busy_fall"}, busy_at_done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        run_frame(0, 0, 5'd0, {9{8'd1}}, 32'd0, 4, 4, 0, 1, 0);
        check_frame("conv_ones", 4, 9, 9, 9, 9);

        run_frame(0, 0, 5'd1, {32'd0, 8'd5, 32'd0}, 32'd0, 3, 3, 0, 1, 0);
        check_frame("round_pos", 1, 3, 0, 0, 0);
        run_frame(0, 0, 5'd1, {32'd0, 8'hFB, 32'd0}, 32'd0, 3, 3, 0, 1, 0);
        check_frame("round_neg", 1, -2, 0, 0, 0);
        run_frame(0, 1, 5'd1, {32'd0, 8'hFB, 32'd0}, 32'd0, 3, 3, 0, 1, 0);
        check_frame("relu", 1, 0, 0, 0, 0);

        run_frame(0, 0, 5'd0, {9{8'h7F}}, 32'd0, 3, 3, 0, 127, 0);
        check_frame("sat_pos", 1, 127, 0, 0, 0);
        run_frame(0, 0, 5'd0, {9{8'h80}}, 32'd0, 3, 3, 0, 127, 0);
        check_frame("sat_neg", 1, -128, 0, 0, 0);

        run_frame(1, 1, 5'd3, {9{8'd1}}, 32'd100, 4, 4, 1, 0, 0);
        check_frame("pool_ramp", 4, 5, 7, 13, 15);

        run_frame(0, 0, 5'd0, {9{8'd1}}, 32'd0, 4, 4, 1, 0, 3);
        check_frame("conv_stall", 4, 45, 54, 81, 90);

        // Abort a max-pool frame with an output still in flight.
        outq.delete(); outc.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        mode = 1'b1; relu_en = 1'b0; shift = '0; width = 8'd4; height = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            pixel_in = 8'd100;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_pixel_out", pixel_out, 0);
        chk("abort_busy", busy, 0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_output", outq.size(), 0);
        chk("abort_no_done", done_cnt, 0);

        run_frame(0, 0, 5'd0, {9{8'd1}}, 32'd0, 4, 4, 0, 1, 0);
        check_frame("after_reset", 4, 9, 9, 9, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream_engine.md
# conv3x3_stream_engine

Streaming 3x3 convolution / 2x2 max-pool engine for the U-Net accelerator datapath, replacing the fixed-width combinational convolutor with a parametrised, pipelined, frame-aware block. It accepts one raster-order pixel per valid beat and keeps two internal line buffers. It emits valid-padding 3x3 convolution results (bias, rounding shift, ReLU, saturation) or stride-2 2x2 max-pool results, framed by start/busy/done.

## Interface
- DATA_W, 8, signed pixel width
- WEIGHT_W, 8, signed weight width
- ACC_W, 32, accumulator and bias width; must satisfy ACC_W >= DATA_W+WEIGHT_W+4
- OUT_W, 8, signed output width after saturation
- MAX_WIDTH, 128, line buffer depth (maximum image width)
- DIM_W, 8, width/height field width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; ignored while busy=1
- mode  in  1  0 = conv3x3, 1 = maxpool2x2; sampled at start
- relu_en  in  1  clamp negative conv results to 0; sampled at start
- shift  in  5  arithmetic right shift for requantisation; sampled at start
- width  in  DIM_W  active image width; sampled at start
- height  in  DIM_W  active image height; sampled at start
- weights  in  9*WEIGHT_W  w(k) = weights[k*WEIGHT_W +: WEIGHT_W], k = 3*row+col, row 0 = oldest row, col 0 = leftmost; sampled at start
- bias  in  ACC_W  signed bias; sampled at start
- in_valid  in  1  pixel_in valid this cycle
- pixel_in  in  DATA_W  signed pixel, raster order
- out_valid  out  1  pixel_out valid this cycle
- pixel_out  out  OUT_W  signed result
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last output of a frame

## Operation
- IDLE: busy=0. On start, latch all configuration and go to RUN. Column and row counters reset to 0.
- RUN: each in_valid beat writes the pixel into the line buffers and window shift register, then advances col (wraps at width-1, then row++). No backpressure. in_valid gaps are allowed and hold all counters.
- Conv: a window is complete when the pixel at (row>=2, col>=2) is accepted. This gives (width-2)*(height-2) outputs per frame.
  - acc = sum over k of w(k)*p(k) + bias, signed, computed in ACC_W.
  - If shift>0, add 1<<(shift-1) and then arithmetic-shift right by shift (round half up). For example, 5 gives 3 and -5 gives -2.
  - If relu_en and the result is negative, the result is 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Maxpool: uses the previous-row buffer. An output is produced when a pixel at odd row and odd col is accepted. The output is the signed max of the 2x2 block, saturated to OUT_W. Shift, bias and relu_en are ignored. This gives (width/2)*(height/2) outputs; a trailing odd row or column is dropped.
- After the last input pixel of the frame (row=height-1, col=width-1) is accepted, go to DRAIN. Wait until the pipeline is empty, then pulse done and return to IDLE.
- Legal configuration:
  - conv: 3<=width<=MAX_WIDTH, height>=3.
  - maxpool: 2<=width<=MAX_WIDTH, height>=2.
  - Behaviour outside these ranges is undefined but must not hang: DRAIN still terminates.
- in_valid outside RUN is ignored.

## Timing
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, pixel_out=0, busy=0, done=0, state IDLE.
  - Counters and pipeline valid bits are cleared.
  - Line buffer contents are not reset and are never used before being rewritten.
- Reset mid-frame aborts the frame immediately. No done pulse and no further out_valid.
- Pipeline, both modes, fixed latency 3:
  - Stage 1 registers the window.
  - Stage 2 registers the 9 products (maxpool: pairwise max).
  - Stage 3 registers the adder tree plus bias (maxpool: final max).
  - Output register applies round/shift/ReLU/saturate.
  - A completing pixel accepted at edge N produces out_valid=1 during the cycle after edge N+3.
- The pipeline advances every cycle regardless of in_valid. Back-to-back outputs are possible at full rate.
- busy rises the cycle after start and falls in the same cycle done pulses.
- done pulses exactly one cycle, in the cycle after the final out_valid.
- start asserted in the same cycle as done is ignored. A new start is accepted from the following cycle.

## Test plan
- Conv, 4x4 frame, all pixels 1, all weights 1, bias 0, shift 0 -> 4 outputs of 9; out_valid 3 cycles after pixels (2,2), (2,3), (3,2), (3,3); done one cycle after the last output.
- Rounding and ReLU: pixels 1, only w(4)=5 (others 0), bias 0, shift 1 -> output 3. With w(4)=-5 -> -2 when relu_en=0, and 0 when relu_en=1.
- Saturation: all pixels 127, weights 127, shift 0 -> 127. Weights -128 with relu_en=0 -> -128.
- Maxpool, 4x4 ramp pixel=row*4+col (0..15) -> outputs 5, 7, 13, 15 in that order; shift, bias and relu_en have no effect.
- Stalls: repeat the conv 4x4 case with random 0–3 cycle in_valid gaps -> identical output values and order; latency measured from each completing pixel remains 3.
- Reset and re-start: assert rst_n=0 after 7 pixels of a frame -> all outputs 0 the next cycle, no done. Then run a fresh 4x4 frame -> correct results, proving no stale line-buffer data leaks into the new frame.
